// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the load/store memory sequencer.
package mem_seq_pkg;

  // Number of 32-bit words in the data memory and the resulting word-address width.
  localparam int unsigned MEM_WORDS = 512;
  localparam int unsigned WORD_AW   = $clog2(MEM_WORDS);

  // Access size encoding as presented by the load/store stage.
  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_e;

  // Sequencer states: waiting, first word, second word of a split, response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC0 = 2'b01,
    ST_ACC1 = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Unshifted byte mask covering the bytes touched by an access of the given size.
  function automatic logic [3:0] size_mask(input size_e size);
    logic [3:0] mask;
    case (size)
      SZ_B:    mask = 4'b0001;
      SZ_H:    mask = 4'b0011;
      SZ_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Request, response and memory-port bundle of the load/store memory sequencer.
interface mem_access_seq_if;

  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [10:0] i_req_addr;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_wdata;

  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  logic [10:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;

  // Sequencer side.
  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned, i_req_wdata,
    input  i_rsp_ready, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );

  // Core and memory side.
  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned, i_req_wdata,
    output i_rsp_ready, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store mask/data shifting and load merge/extension.
module mem_lane_align
  import mem_seq_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [23:0] hi,
  input  logic        is_unsigned,
  output logic [7:0]  m8,
  output logic [63:0] d64,
  output logic [31:0] rdata
);

  logic [31:0] merged_s;

  // Spread the store mask and data across two words according to the byte offset.
  always_comb begin
    m8  = {4'b0000, size_mask(size)} << off;
    d64 = {32'h0000_0000, wdata} << {off, 3'b000};
  end

  // Right-justify load data; only the low three bytes of the second word can ever be needed.
  always_comb begin
    case (off)
      2'd0:    merged_s = lo;
      2'd1:    merged_s = {hi[7:0],  lo[31:8]};
      2'd2:    merged_s = {hi[15:0], lo[31:16]};
      2'd3:    merged_s = {hi[23:0], lo[31:24]};
      default: merged_s = 32'h0000_0000;
    endcase
  end

  // Sign- or zero-extend the right-justified load value to 32 bits.
  always_comb begin
    case (size)
      SZ_B: begin
        if (is_unsigned) begin
          rdata = {24'h00_0000, merged_s[7:0]};
        end else begin
          rdata = {{24{merged_s[7]}}, merged_s[7:0]};
        end
      end
      SZ_H: begin
        if (is_unsigned) begin
          rdata = {16'h0000, merged_s[15:0]};
        end else begin
          rdata = {{16{merged_s[15]}}, merged_s[15:0]};
        end
      end
      SZ_W:    rdata = merged_s;
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer: one request at a time, splits word-crossing accesses into two cycles.
module mem_access_seq
  import mem_seq_pkg::*;
(
  input logic             i_clk,
  input logic             i_reset,
  mem_access_seq_if.slave bus
);

  state_e               state_r;
  state_e               state_next_s;

  logic                 req_we_r;
  logic [10:0]          req_addr_r;
  size_e                req_size_r;
  logic                 req_unsigned_r;
  logic [31:0]          req_wdata_r;
  logic [31:0]          lo_r;
  logic [31:0]          rsp_rdata_r;
  logic                 rsp_err_r;

  logic [7:0]           m8_s;
  logic [63:0]          d64_s;
  logic [31:0]          ld_data_s;
  logic [31:0]          lo_sel_s;
  logic [23:0]          hi_sel_s;
  logic                 split_s;
  logic [WORD_AW-1:0]   word_s;
  logic [WORD_AW-1:0]   word_next_s;

  logic                 req_ready_s;
  logic                 rsp_valid_s;
  logic [10:0]          mem_addr_s;
  logic [31:0]          mem_wdata_s;
  logic [3:0]           mem_bmask_s;
  logic                 mem_wren_s;

  assign split_s     = |m8_s[7:4];
  assign word_s      = req_addr_r[10:2];
  assign word_next_s = word_s + 9'd1;  // word 511 wraps to word 0

  mem_lane_align u_align (
    .size        (req_size_r),
    .off         (req_addr_r[1:0]),
    .wdata       (req_wdata_r),
    .lo          (lo_sel_s),
    .hi          (hi_sel_s),
    .is_unsigned (req_unsigned_r),
    .m8          (m8_s),
    .d64         (d64_s),
    .rdata       (ld_data_s)
  );

  // Low word comes straight from memory in ACC0 and from the capture register in ACC1.
  always_comb begin
    if (state_r == ST_ACC1) begin
      lo_sel_s = lo_r;
      hi_sel_s = bus.i_mem_rdata[23:0];
    end else begin
      lo_sel_s = bus.i_mem_rdata;
      hi_sel_s = 24'h00_0000;
    end
  end

  // State register; reset forces IDLE so nothing in flight survives it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          if (size_e'(bus.i_req_size) == SZ_ILL) begin
            state_next_s = ST_RESP;
          end else begin
            state_next_s = ST_ACC0;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACC0: begin
        if (split_s) begin
          state_next_s = ST_ACC1;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      ST_ACC1: state_next_s = ST_RESP;
      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode; reset gates handshakes and write enable so an aborted split stops at once.
  always_comb begin
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    mem_addr_s  = 11'd0;
    mem_wdata_s = 32'h0000_0000;
    mem_bmask_s = 4'b0000;
    mem_wren_s  = 1'b0;
    case (state_r)
      ST_IDLE: req_ready_s = ~i_reset;
      ST_ACC0: begin
        mem_addr_s  = {2'b00, word_s};
        mem_wdata_s = d64_s[31:0];
        mem_bmask_s = m8_s[3:0];
        mem_wren_s  = req_we_r & ~i_reset;
      end
      ST_ACC1: begin
        mem_addr_s  = {2'b00, word_next_s};
        mem_wdata_s = d64_s[63:32];
        mem_bmask_s = m8_s[7:4];
        mem_wren_s  = req_we_r & ~i_reset;
      end
      ST_RESP: rsp_valid_s = ~i_reset;
      default: req_ready_s = 1'b0;
    endcase
  end

  // Request capture on acceptance, low-word capture, and response data/error assembly.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      req_we_r       <= 1'b0;
      req_addr_r     <= 11'd0;
      req_size_r     <= SZ_B;
      req_unsigned_r <= 1'b0;
      req_wdata_r    <= 32'h0000_0000;
      lo_r           <= 32'h0000_0000;
      rsp_rdata_r    <= 32'h0000_0000;
      rsp_err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_req_valid) begin
            req_we_r       <= bus.i_req_we;
            req_addr_r     <= bus.i_req_addr;
            req_size_r     <= size_e'(bus.i_req_size);
            req_unsigned_r <= bus.i_req_unsigned;
            req_wdata_r    <= bus.i_req_wdata;
            rsp_rdata_r    <= 32'h0000_0000;
            rsp_err_r      <= (size_e'(bus.i_req_size) == SZ_ILL);
          end
        end
        ST_ACC0: begin
          lo_r <= bus.i_mem_rdata;
          if (!req_we_r && !split_s) begin
            rsp_rdata_r <= ld_data_s;
          end
        end
        ST_ACC1: begin
          if (!req_we_r) begin
            rsp_rdata_r <= ld_data_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_req_ready = req_ready_s;
  assign bus.o_rsp_valid = rsp_valid_s;
  assign bus.o_rsp_rdata = rsp_rdata_r;
  assign bus.o_rsp_err   = rsp_err_r;
  assign bus.o_mem_addr  = mem_addr_s;
  assign bus.o_mem_wdata = mem_wdata_s;
  assign bus.o_mem_bmask = mem_bmask_s;
  assign bus.o_mem_wren  = mem_wren_s;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed self-checking bench for mem_access_seq with a byte-masked memory model.
module tb_mem_access_seq;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;

  mem_access_seq_if bus ();

  mem_access_seq dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  logic [31:0] mem [0:511];
  int          wr_cnt;
  int          n_pass  = 0;
  int          n_total = 0;

  assign bus.i_mem_rdata = mem[bus.o_mem_addr[8:0]];

  // Byte-masked memory model with a write counter.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      wr_cnt <= 0;
    end else if (bus.o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_bmask[b]) mem[bus.o_mem_addr[8:0]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One full transaction with rsp_ready held high; caller is at a negedge with the DUT idle.
  task automatic xfer(input string tag, input logic we, input logic [10:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wd,
                      input logic split,
                      input logic [10:0] a0, input logic [3:0] m0, input logic [31:0] d0,
                      input logic [10:0] a1, input logic [3:0] m1, input logic [31:0] d1,
                      input logic [31:0] rd);
    bus.i_req_valid    = 1'b1;
    bus.i_req_we       = we;
    bus.i_req_addr     = addr;
    bus.i_req_size     = size;
    bus.i_req_unsigned = uns;
    bus.i_req_wdata    = wd;
    chk({tag, ".ready"}, 32'(bus.o_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    chk({tag, ".a0"},    32'(bus.o_mem_addr),  32'(a0));
    chk({tag, ".m0"},    32'(bus.o_mem_bmask), 32'(m0));
    chk({tag, ".d0"},    bus.o_mem_wdata,      d0);
    chk({tag, ".we0"},   32'(bus.o_mem_wren),  32'(we));
    chk({tag, ".early"}, 32'(bus.o_rsp_valid), 32'd0);
    @(negedge clk);
    if (split) begin
      chk({tag, ".a1"},  32'(bus.o_mem_addr),  32'(a1));
      chk({tag, ".m1"},  32'(bus.o_mem_bmask), 32'(m1));
      chk({tag, ".d1"},  bus.o_mem_wdata,      d1);
      chk({tag, ".we1"}, 32'(bus.o_mem_wren),  32'(we));
      chk({tag, ".early1"}, 32'(bus.o_rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk({tag, ".rvalid"}, 32'(bus.o_rsp_valid), 32'd1);
    chk({tag, ".rerr"},   32'(bus.o_rsp_err),   32'd0);
    chk({tag, ".rdata"},  bus.o_rsp_rdata,      rd);
    chk({tag, ".memidle"}, {bus.o_mem_wdata[31:6], bus.o_mem_bmask, bus.o_mem_wren, 1'b0} | 32'(bus.o_mem_addr), 32'd0);
    @(negedge clk);
    chk({tag, ".rdone"},  32'(bus.o_rsp_valid), 32'd0);
    chk({tag, ".rdy2"},   32'(bus.o_req_ready), 32'd1);
  endtask

  // Directed sequence.
  initial begin
    rst                = 1'b1;
    mem_clr            = 1'b1;
    bus.i_req_valid    = 1'b1;   // must be ignored while reset is high
    bus.i_req_we       = 1'b1;
    bus.i_req_addr     = 11'h000;
    bus.i_req_size     = 2'b10;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_wdata    = 32'hFFFF_FFFF;
    bus.i_rsp_ready    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.ready_in_reset", 32'(bus.o_req_ready), 32'd0);
    rst             = 1'b0;
    mem_clr         = 1'b0;
    bus.i_req_valid = 1'b0;
    #1;
    chk("rst.ready",  32'(bus.o_req_ready), 32'd1);
    chk("rst.rvalid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst.rdata",  bus.o_rsp_rdata,      32'd0);
    chk("rst.rerr",   32'(bus.o_rsp_err),   32'd0);
    chk("rst.mem",    {bus.o_mem_wdata[31:6], bus.o_mem_bmask, bus.o_mem_wren, 1'b0} | 32'(bus.o_mem_addr), 32'd0);
    @(negedge clk);

    // Aligned word store/load.
    xfer("stw", 1'b1, 11'h010, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0,
         11'd4, 4'hF, 32'hDEAD_BEEF, 11'd0, 4'h0, 32'h0, 32'h0);
    chk("stw.mem4", mem[4], 32'hDEAD_BEEF);
    xfer("ldw", 1'b0, 11'h010, 2'b10, 1'b0, 32'h0, 1'b0,
         11'd4, 4'hF, 32'h0, 11'd0, 4'h0, 32'h0, 32'hDEAD_BEEF);

    // Byte store in the top lane, signed and unsigned reload.
    xfer("stb", 1'b1, 11'h013, 2'b00, 1'b0, 32'h0000_0080, 1'b0,
         11'd4, 4'h8, 32'h8000_0000, 11'd0, 4'h0, 32'h0, 32'h0);
    chk("stb.mem4", mem[4], 32'h80AD_BEEF);
    xfer("ldbs", 1'b0, 11'h013, 2'b00, 1'b0, 32'h0, 1'b0,
         11'd4, 4'h8, 32'h0, 11'd0, 4'h0, 32'h0, 32'hFFFF_FF80);
    xfer("ldbu", 1'b0, 11'h013, 2'b00, 1'b1, 32'h0, 1'b0,
         11'd4, 4'h8, 32'h0, 11'd0, 4'h0, 32'h0, 32'h0000_0080);

    // Split halfword store/load across words 1 and 2.
    xfer("sth", 1'b1, 11'h007, 2'b01, 1'b0, 32'h0000_A55A, 1'b1,
         11'd1, 4'h8, 32'h5A00_0000, 11'd2, 4'h1, 32'h0000_00A5, 32'h0);
    chk("sth.mem1", mem[1], 32'h5A00_0000);
    chk("sth.mem2", mem[2], 32'h0000_00A5);
    xfer("ldhu", 1'b0, 11'h007, 2'b01, 1'b1, 32'h0, 1'b1,
         11'd1, 4'h8, 32'h0, 11'd2, 4'h1, 32'h0, 32'h0000_A55A);
    xfer("ldhs", 1'b0, 11'h007, 2'b01, 1'b0, 32'h0, 1'b1,
         11'd1, 4'h8, 32'h0, 11'd2, 4'h1, 32'h0, 32'hFFFF_A55A);

    // Word store/load wrapping from word 511 to word 0.
    xfer("stwrap", 1'b1, 11'h7FE, 2'b10, 1'b0, 32'h1122_3344, 1'b1,
         11'd511, 4'hC, 32'h3344_0000, 11'd0, 4'h3, 32'h0000_1122, 32'h0);
    chk("stwrap.mem511", mem[511], 32'h3344_0000);
    chk("stwrap.mem0",   mem[0],   32'h0000_1122);
    xfer("ldwrap", 1'b0, 11'h7FE, 2'b10, 1'b0, 32'h0, 1'b1,
         11'd511, 4'hC, 32'h0, 11'd0, 4'h3, 32'h0, 32'h1122_3344);
    chk("wrcnt.a", 32'(wr_cnt), 32'd6);

    // Illegal size with a stalled response.
    bus.i_rsp_ready    = 1'b0;
    bus.i_req_valid    = 1'b1;
    bus.i_req_we       = 1'b1;
    bus.i_req_addr     = 11'h020;
    bus.i_req_size     = 2'b11;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_wdata    = 32'h1234_5678;
    chk("ill.ready", 32'(bus.o_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    chk("ill.rvalid", 32'(bus.o_rsp_valid), 32'd1);
    chk("ill.wren",   32'(bus.o_mem_wren),  32'd0);
    for (int c = 0; c < 5; c++) begin
      chk("ill.hold_valid", 32'(bus.o_rsp_valid), 32'd1);
      chk("ill.hold_err",   32'(bus.o_rsp_err),   32'd1);
      chk("ill.hold_rdata", bus.o_rsp_rdata,      32'd0);
      chk("ill.hold_ready", 32'(bus.o_req_ready), 32'd0);
      @(negedge clk);
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    chk("ill.done_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("ill.done_ready", 32'(bus.o_req_ready), 32'd1);
    chk("wrcnt.b", 32'(wr_cnt), 32'd6);

    // Reset during the second cycle of a split word store at 0x101.
    bus.i_req_valid    = 1'b1;
    bus.i_req_we       = 1'b1;
    bus.i_req_addr     = 11'h101;
    bus.i_req_size     = 2'b10;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_wdata    = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    chk("abort.a0", 32'(bus.o_mem_addr),  32'd64);
    chk("abort.m0", 32'(bus.o_mem_bmask), 32'hE);
    chk("abort.d0", bus.o_mem_wdata,      32'hFEF0_0D00);
    @(negedge clk);
    chk("abort.a1", 32'(bus.o_mem_addr),  32'd65);
    chk("abort.m1", 32'(bus.o_mem_bmask), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort.wren_gated", 32'(bus.o_mem_wren), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.ready",  32'(bus.o_req_ready), 32'd1);
    chk("abort.rvalid", 32'(bus.o_rsp_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort.no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    end
    chk("abort.mem64", mem[64], 32'hFEF0_0D00);
    chk("abort.mem65", mem[65], 32'h0000_0000);
    chk("wrcnt.c", 32'(wr_cnt), 32'd7);

    // Normal operation after the abort.
    xfer("ldpost", 1'b0, 11'h100, 2'b10, 1'b0, 32'h0, 1'b0,
         11'd64, 4'hF, 32'h0, 11'd0, 4'h0, 32'h0, 32'hFEF0_0D00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Sequencer between the core's load/store stage and the 2 KiB byte-masked data memory. Accepts one byte/halfword/word request at a time over a valid/ready handshake, generates word address, byte mask and shifted write data, and splits accesses that cross a word boundary into two memory cycles. Load data is merged, shifted and sign- or zero-extended before being returned on a response handshake.

## Interface
Parameters: none (memory geometry fixed: 2048 bytes, 512 words).
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high; clock i_clk
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted when valid && ready
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  11  byte address
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_req_unsigned  in  1  load zero-extend (1) / sign-extend (0)
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  response pending
- i_rsp_ready  in  1  response consumed when valid && ready
- o_rsp_rdata  out  32  extended load data; 0 for stores/errors
- o_rsp_err  out  1  illegal size
- o_mem_addr  out  11  memory word address
- o_mem_wdata  out  32  memory write data
- o_mem_bmask  out  4  memory byte mask
- o_mem_wren  out  1  memory write enable
- i_mem_rdata  in  32  memory read data (combinational, same cycle)

## Operation
- States: IDLE, ACC0, ACC1, RESP. Request fields registered on acceptance.
- IDLE: o_req_ready=1; on accept -> ACC0, or -> RESP with o_rsp_err=1 if size=11 (no memory access).
- off = addr[1:0]; w = addr[10:2]; smask = 0001/0011/1111 per size; m8 = smask << off (8 bits); d64 = wdata << 8*off (64 bits).
- ACC0: o_mem_addr={2'b00,w}, bmask=m8[3:0], wdata=d64[31:0], wren=we. Load: capture i_mem_rdata as lo. -> ACC1 if m8[7:4]!=0, else RESP.
- ACC1: o_mem_addr={2'b00,(w+1) mod 512} (word 511 wraps to 0), bmask=m8[7:4], wdata=d64[63:32], wren=we. Load: capture hi. -> RESP.
- Load result: ({hi,lo} >> 8*off), low 8/16/32 bits extended per i_req_unsigned; hi=0 when no split.
- Loads still drive bmask (memory ignores it with wren=0).
- RESP: o_rsp_valid=1, data/err held stable until i_rsp_ready; then -> IDLE.
- Outside ACC0/ACC1 all o_mem_* are 0.

## Timing
- Reset: state IDLE; o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, all o_mem_* 0 in the first cycle after deassertion. Requests while i_reset=1 are not accepted.
- Accept at edge k: ACC0 in cycle k+1, store write at edge k+1. Aligned: o_rsp_valid from cycle k+2. Split: ACC1 cycle k+2, second write at edge k+2, o_rsp_valid from cycle k+3. Illegal: o_rsp_valid from cycle k+1.
- Response consumed at edge j (valid && ready) -> o_req_ready=1 in cycle j+1; minimum issue interval 3 cycles aligned, 4 split.
- i_rsp_ready held high: RESP lasts exactly one cycle.
- Reset mid-operation returns to IDLE immediately; a split store reset during ACC1 leaves only the first half written (defined, not an error). No response is produced for aborted requests.

## Structure
- mem_seq_pkg: size typedef (SZ_B, SZ_H, SZ_W, SZ_ILL), state enum, MEM_WORDS=512 constant.
- Sub-module mem_lane_align (combinational): smask/m8, d64 shift, load merge/extend. Top holds FSM and capture registers.

## Test plan
- Reset, then aligned store word 0xDEADBEEF @0x010, load word @0x010 -> memory write at word 4 bmask 1111; rsp_rdata 0xDEADBEEF, response 2 cycles after accept.
- Store byte 0x80 @0x013, load byte signed @0x013 -> bmask 1000 wdata 0x80000000; rdata 0xFFFFFF80; unsigned -> 0x00000080.
- Store half 0xA55A @0x007 (split) -> ACC0 word 1 bmask 1000, ACC1 word 2 bmask 0001; unsigned half load @0x007 returns 0x0000A55A, response 3 cycles after accept.
- Word store 0x11223344 @0x7FE -> words 511 (bmask 1100) and 0 (bmask 0011); word load @0x7FE returns 0x11223344.
- size=11 request -> no o_mem_wren, o_rsp_err=1, rdata 0; i_rsp_ready low 5 cycles -> response held, o_req_ready stays 0.
- Reset asserted during ACC1 of split store -> only first word modified, o_rsp_valid never rises, o_req_ready=1 the cycle after reset drops.
